// File: rtl/crc16_serial_tx.sv
// -----------------------------------------------------------------------------
// crc16_serial_tx
//
// Transmit framer for a bit-serial CRC-16 link (polynomial x^16+x^12+x^5+1).
// Payload bytes arrive over a valid/ready handshake. Each byte is sent
// MSB-first on ser_data, and the 16-bit remainder follows MSB-first. A
// bit-serial checker that uses the same polynomial and init value therefore
// ends every frame with a zero remainder.
//
// Configuration macro:
//   CRC16_TX_INIT_ONES_EN  defined   -> INIT = 16'hFFFF (CRC-16/CCITT-FALSE)
//                          undefined -> INIT = 16'h0000 (CRC-16/XMODEM)
//
// Ports:
//   Clk         in   clock, rising edge
//   R           in   asynchronous active-low reset
//   start       in   frame request, sampled only in IDLE
//   len         in   payload byte count (LEN_W bits), 0 = ignore start
//   byte_data   in   payload byte
//   byte_valid  in   byte_data valid
//   byte_ready  out  byte accepted this cycle when byte_valid is also high
//   ser_data    out  serial bit
//   ser_valid   out  ser_data carries a frame bit
//   crc_phase   out  CRC bits are on ser_data
//   busy        out  any state other than IDLE
//   done        out  one-cycle pulse after the last CRC bit
//   crc_out     out  remainder of the last frame
//   dbg_state   out  current FSM state (IDLE=0 LOAD=1 SHIFT=2 CRC=3 DONE=4)
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high. byte_ready does not depend on byte_valid, and
// byte_valid without byte_ready consumes nothing.
// -----------------------------------------------------------------------------
module crc16_serial_tx #(
    parameter int LEN_W = 8
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             crc_phase,
    output logic             busy,
    output logic             done,
    output logic [15:0]      crc_out,
    output logic [2:0]       dbg_state
);

`ifdef CRC16_TX_INIT_ONES_EN
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
`else
    localparam logic [15:0] CRC_INIT = 16'h0000;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CRC   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic [3:0]       ccnt_q, ccnt_d;
    logic [15:0]      crc_out_q, crc_out_d;

    // Bit-serial CRC step for the payload bit currently on ser_data.
    logic        fb;
    logic [15:0] crc_upd;
    assign fb      = sh_q[7] ^ crc_q[15];
    assign crc_upd = {crc_q[14:12], crc_q[11] ^ fb, crc_q[10:5],
                      crc_q[4] ^ fb, crc_q[3:0], fb};

    logic more_bytes;
    assign more_bytes = (left_q > LEN_W'(1));

    // State register
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q   <= S_IDLE;
            crc_q     <= 16'h0000;
            sh_q      <= 8'h00;
            bitcnt_q  <= 3'd0;
            left_q    <= '0;
            ccnt_q    <= 4'd0;
            crc_out_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            sh_q      <= sh_d;
            bitcnt_q  <= bitcnt_d;
            left_q    <= left_d;
            ccnt_q    <= ccnt_d;
            crc_out_q <= crc_out_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        sh_d      = sh_q;
        bitcnt_d  = bitcnt_q;
        left_d    = left_q;
        ccnt_d    = ccnt_q;
        crc_out_d = crc_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    left_d  = len;
                    crc_d   = CRC_INIT;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    sh_d     = byte_data;
                    bitcnt_d = 3'd7;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                crc_d    = crc_upd;
                sh_d     = {sh_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q - 3'd1;
                if (bitcnt_q == 3'd0) begin
                    if (more_bytes) begin
                        // The byte count drops as the current byte
                        // finishes. A stall does the same, so LOAD never
                        // needs to decrement it.
                        left_d = left_q - LEN_W'(1);
                        if (byte_valid) begin
                            sh_d     = byte_data;
                            bitcnt_d = 3'd7;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        crc_out_d = crc_upd;
                        ccnt_d    = 4'd0;
                        state_d   = S_CRC;
                    end
                end
            end
            S_CRC: begin
                // Plain shift-out of the remainder, no feedback.
                crc_d  = {crc_q[14:0], 1'b0};
                ccnt_d = ccnt_q + 4'd1;
                if (ccnt_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        byte_ready = 1'b0;
        ser_data   = 1'b0;
        ser_valid  = 1'b0;
        crc_phase  = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                byte_ready = 1'b1;
            end
            S_SHIFT: begin
                ser_valid  = 1'b1;
                ser_data   = sh_q[7];
                byte_ready = (bitcnt_q == 3'd0) && more_bytes;
            end
            S_CRC: begin
                ser_valid = 1'b1;
                crc_phase = 1'b1;
                ser_data  = crc_q[15];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign crc_out   = crc_out_q;
    assign dbg_state = state_q;

endmodule
